// File: rtl/time_counter_if.sv
// Control inputs and BCD time-of-day outputs of the time_counter block.
interface time_counter_if;
  logic       run;
  logic       set_min;
  logic       set_hour;
  logic [3:0] min;
  logic [3:0] minten;
  logic [3:0] hour;
  logic [3:0] hourten;
  logic       pm;
  logic       sec_tick;
  logic       min_tick;

  modport master (
    output run, set_min, set_hour,
    input  min, minten, hour, hourten, pm, sec_tick, min_tick
  );

  modport slave (
    input  run, set_min, set_hour,
    output min, minten, hour, hourten, pm, sec_tick, min_tick
  );
endinterface

// File: rtl/time_counter.sv
// 12-hour BCD time-of-day keeper: prescales clk to 1 Hz, counts seconds,
// minutes and hours, and applies debounced set_min / set_hour pulses.
module time_counter #(
  parameter int unsigned SEC_DIV = 100_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  time_counter_if.slave bus
);

  localparam int unsigned PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SEC_DIV - 1);

  logic [PW-1:0] presc;
  logic [5:0]    sec;
  logic [3:0]    min_r, minten_r, hour_r, hourten_r;
  logic          pm_r, sec_tick_r, min_tick_r;

  logic sec_evt, min_evt, min_adv, min_wrap, hour_carry, hour_adv;

  // A set_min pulse swallows the natural second/minute event of its cycle,
  // so it can never also carry into the hour.
  always_comb begin
    sec_evt    = bus.run && (presc == LAST) && !bus.set_min;
    min_evt    = sec_evt && (sec == 6'd59);
    min_adv    = min_evt || bus.set_min;
    min_wrap   = (min_r == 4'd9);
    hour_carry = min_evt && min_wrap && (minten_r == 4'd5);
    hour_adv   = hour_carry || bus.set_hour;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      sec        <= '0;
      min_r      <= '0;
      minten_r   <= '0;
      hour_r     <= 4'd2;
      hourten_r  <= 4'd1;
      pm_r       <= 1'b0;
      sec_tick_r <= 1'b0;
      min_tick_r <= 1'b0;
    end else begin
      sec_tick_r <= sec_evt;
      min_tick_r <= min_evt;

      if (bus.set_min) begin
        presc <= '0;
        sec   <= '0;
      end else begin
        if (bus.run)
          presc <= (presc == LAST) ? '0 : presc + PW'(1);
        if (sec_evt)
          sec <= (sec == 6'd59) ? '0 : sec + 6'd1;
      end

      if (min_adv) begin
        if (min_wrap) begin
          min_r    <= '0;
          minten_r <= (minten_r == 4'd5) ? '0 : minten_r + 4'd1;
        end else begin
          min_r <= min_r + 4'd1;
        end
      end

      // Hour runs 12,1..9,10,11,12; pm flips on the 11 -> 12 step.
      if (hour_adv) begin
        if (hourten_r == 4'd1 && hour_r == 4'd2) begin
          hourten_r <= '0;
          hour_r    <= 4'd1;
        end else if (hourten_r == 4'd0 && hour_r == 4'd9) begin
          hourten_r <= 4'd1;
          hour_r    <= '0;
        end else begin
          hour_r <= hour_r + 4'd1;
          if (hourten_r == 4'd1 && hour_r == 4'd1)
            pm_r <= ~pm_r;
        end
      end
    end
  end

  assign bus.min      = min_r;
  assign bus.minten   = minten_r;
  assign bus.hour     = hour_r;
  assign bus.hourten  = hourten_r;
  assign bus.pm       = pm_r;
  assign bus.sec_tick = sec_tick_r;
  assign bus.min_tick = min_tick_r;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: a reference time model predicts each
// cycle's outputs, a monitor compares them on the falling edge.
module tb_time_counter;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_counter_if bus();

  time_counter #(.SEC_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          tag;
    logic [15:0] digits;
    logic        pm;
    logic        st;
    logic        mt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  event imm_ev;

  // Reference model: plain hour/minute/second numbers.
  int h, m, s, ps;
  bit pm_m;

  always @(posedge clk) cyc++;

  function automatic exp_t snap(int tag, bit st, bit mt);
    exp_t e;
    e.tag    = tag;
    e.digits = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    e.pm     = pm_m;
    e.st     = st;
    e.mt     = mt;
    return e;
  endfunction

  task automatic model_reset();
    h = 12; m = 0; s = 0; ps = 0; pm_m = 1'b0;
  endtask

  // Called #2 after a rising edge; returns #2 after the next one.
  task automatic step(bit r, bit sm, bit sh);
    bit sev, mev, hc;
    bus.run = r; bus.set_min = sm; bus.set_hour = sh;
    sev = r && (ps == DIV - 1) && !sm;
    mev = 1'b0;
    hc  = 1'b0;
    if (sm) begin
      ps = 0; s = 0; m = (m + 1) % 60;
    end else if (r) begin
      ps = (ps + 1) % DIV;
    end
    if (sev) begin
      if (s == 59) begin
        s = 0; mev = 1'b1; m = (m + 1) % 60; hc = (m == 0);
      end else begin
        s++;
      end
    end
    if (hc || sh) begin
      h = h % 12 + 1;
      if (h == 12) pm_m = !pm_m;
    end
    sb.push_back(snap(cyc + 1, sev, mev));
    @(posedge clk); #2;
  endtask

  // Asserts rst_n between edges, checks outputs at once, holds through one
  // edge, then releases.
  task automatic do_reset();
    bus.run = 1'b0; bus.set_min = 1'b0; bus.set_hour = 1'b0;
    #5;
    rst_n = 1'b0;
    model_reset();
    sb.push_back(snap(cyc, 1'b0, 1'b0));
    #1 -> imm_ev;
    sb.push_back(snap(cyc + 1, 1'b0, 1'b0));
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic run_until(int ts, bit need_last);
    int i;
    i = 0;
    while (!(s == ts && (!need_last || ps == DIV - 1)) && i < 1000) begin
      step(1'b1, 1'b0, 1'b0);
      i++;
    end
    if (!(s == ts && (!need_last || ps == DIV - 1))) begin
      checks++;
      errors++;
      $display("FAIL run_until: seconds=%0d prescaler=%0d required seconds=%0d", s, ps, ts);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or imm_ev);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if ({bus.hourten, bus.hour, bus.minten, bus.min, bus.pm} !== {mon_e.digits, mon_e.pm}) begin
          errors++;
          $display("FAIL time cyc=%0d got %h pm=%b required %h pm=%b", cyc,
                   {bus.hourten, bus.hour, bus.minten, bus.min}, bus.pm, mon_e.digits, mon_e.pm);
        end
        checks++;
        if ({bus.sec_tick, bus.min_tick} !== {mon_e.st, mon_e.mt}) begin
          errors++;
          $display("FAIL ticks cyc=%0d got sec=%b min=%b required sec=%b min=%b", cyc,
                   bus.sec_tick, bus.min_tick, mon_e.st, mon_e.mt);
        end
      end
    end
  end

  initial begin
    bus.run = 1'b0; bus.set_min = 1'b0; bus.set_hour = 1'b0;
    model_reset();
    @(posedge clk); #2;
    do_reset();

    // Free run to 12:01 with the first natural minute rollover.
    repeat (240) step(1'b1, 1'b0, 1'b0);

    // Pause mid-count, resume, then reset mid-count.
    repeat (6)  step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    do_reset();

    // 12:59:59 AM -> 1:00:00 AM, then a set_hour merged with the hour carry.
    repeat (59) step(1'b0, 1'b1, 1'b0);
    run_until(59, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (59) step(1'b0, 1'b1, 1'b0);
    run_until(59, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0);

    // 11:59:59 PM -> 12:00:00 AM, passing 9->10 and 11->12 on the way.
    do_reset();
    repeat (23) step(1'b0, 1'b0, 1'b1);
    repeat (59) step(1'b0, 1'b1, 1'b0);
    run_until(59, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0);

    // set_min at minute 59 mid-second, and coincident with a rollover.
    do_reset();
    repeat (59) step(1'b0, 1'b1, 1'b0);
    run_until(30, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (58) step(1'b0, 1'b1, 1'b0);
    run_until(59, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    run_until(59, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Randomised traffic.
    repeat (3000)
      step($urandom_range(7) != 0, $urandom_range(29) == 0, $urandom_range(29) == 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_counter.md
# time_counter

Time-of-day keeper for the alarm clock. It divides the system clock down to a 1 Hz tick, counts seconds, minutes and hours in BCD in 12-hour format, and accepts set pulses from the button front end. Its four BCD digit outputs drive the segment decoder, which has no entries for codes above 9, so every digit value produced here is always in range.

## Interface
- SEC_DIV, 100_000_000: clk cycles per second (≥2); benches use 4.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = timekeeping advances; 0 = prescaler and seconds hold.
- set_min  in  1  one-cycle pulse, already debounced and synchronised; advances the minute by one.
- set_hour  in  1  one-cycle pulse, already debounced and synchronised; advances the hour by one.
- min  out  4  minute units, BCD 0–9.
- minten  out  4  minute tens, BCD 0–5.
- hour  out  4  hour units, BCD 0–9.
- hourten  out  4  hour tens, BCD 0–1.
- pm  out  1  0 = AM, 1 = PM.
- sec_tick  out  1  one-cycle pulse per elapsed second.
- min_tick  out  1  one-cycle pulse on each natural minute rollover, used by the alarm compare.

## Operation
- Reset (asynchronous, while rst_n=0):
  - Time is 12:00:00 AM: hourten=1, hour=2, minten=0, min=0, pm=0.
  - Prescaler=0, seconds=0, sec_tick=0, min_tick=0.
- Prescaler: counts 0..SEC_DIV-1 while run=1.
  - At SEC_DIV-1 it wraps to 0 and generates a second event.
  - While run=0 it holds its value.
- Seconds: internal binary counter, 0..59. A second event increments it; at 59 it wraps to 0 and generates a minute event.
- Minute event (natural rollover):
  - min increments; 9 wraps to 0 with a carry into minten.
  - minten 5 with a carry wraps to 0 and generates an hour carry.
- Hour sequence (valid values are only 1–12):
  - 12 → 1 (hourten 1→0, hour 2→1).
  - 9 → 10 (hourten 0→1, hour 9→0).
  - 11 → 12 toggles pm.
- set_min:
  - Clears seconds and the prescaler.
  - Advances the minute by one; 59 wraps to 00 with no hour carry.
  - Suppresses any second event or minute event in the same cycle; no min_tick is generated.
- set_hour:
  - Advances the hour by one along the same sequence, including the pm toggle at 11→12.
  - Seconds and minutes are unaffected.
  - An hour carry from a natural rollover in the same cycle is merged with it, so the hour advances by one only.
- set_min and set_hour in the same cycle: both apply independently.
- set_min and set_hour act regardless of run.
- No illegal digit combination can be reached.

## Timing
- All outputs are registered; no combinational path runs from inputs to outputs.
- Second event at edge N:
  - Digits reflect the new time after edge N.
  - sec_tick is high for exactly the cycle after edge N.
  - min_tick is high in that same cycle if the event rolled the minute.
- Set pulses: sampled at edge N; updated digits are visible after edge N (latency 1).
- run deasserted mid-count: the prescaler freezes at its current value and resumes from it; no tick is lost or duplicated.
- rst_n asserted mid-operation: all state returns to reset values immediately.
- rst_n release: counting starts on the first rising edge that samples rst_n=1.
- Full rollover 12:59:59 → 1:00:00: a single edge, with pm unchanged.

## Test plan
- Reset, run=1, SEC_DIV=4:
  - sec_tick pulses every 4 cycles.
  - After 240 cycles the display reads 12:01, with min_tick pulsing once at cycle 240.
- Preload 11:59:59 PM via set pulses and second events, then one second event:
  - Display reads 12:00 AM (hourten=1, hour=2, minten=0, min=0, pm=0).
  - min_tick=1 for one cycle.
- From 12:59:59 AM, one second event: display reads 1:00 (hourten=0, hour=1), pm stays 0.
- From 9:xx AM, set_hour: display reads 10 (hourten=1, hour=0); a further set_hour gives 11, and a further set_hour gives 12 with pm=1.
- From minute 59 with seconds=30, set_min:
  - Minute reads 00 with the hour unchanged, seconds=0 and no min_tick.
  - A set_min coincident with a natural rollover advances the minute by exactly one.
- run=0 for 10 cycles mid-count, then rst_n pulsed low mid-count:
  - While run=0 there is no sec_tick and the digits hold; the tick resumes on schedule after run returns to 1.
  - The rst_n pulse returns the outputs to 12:00 AM immediately.
